// File: rtl/raster_block_pkg.sv
// Shared constants and types for the raster-to-block converter: block geometry,
// luma coefficients and the read-side state encoding.
package raster_block_pkg;

    localparam int BLK_N         = 8;
    localparam int BEATS_PER_BLK = 32;

    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } rd_state_t;

endpackage

// File: rtl/luma_conv.sv
// One-pixel RGB to luma converter with a single output register stage.
module luma_conv
    import raster_block_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] y
);

    // Weights sum to 256, so the rounded 16-bit sum never exceeds 255 after the shift.
    function automatic logic [7:0] to_luma(input logic [7:0] rr, input logic [7:0] gg,
                                           input logic [7:0] bb);
        logic [15:0] acc;
        acc = LUMA_R * {8'd0, rr} + LUMA_G * {8'd0, gg} + LUMA_B * {8'd0, bb} + 16'd128;
        return acc[15:8];
    endfunction

    // p0 -> p1: luma registered the cycle after the pixel is presented
    always_ff @(posedge clk) begin
        y <= to_luma(r, g, b);
    end

endmodule

// File: rtl/raster_to_block.sv
// Converts a two-pixel-per-cycle raster stream into 8x8 luma blocks, using a
// ping-pong pair of 8-row band buffers and a ready/valid block output.
module raster_to_block
    import raster_block_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HSYNC,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic       BLK_VALID,
    input  logic       BLK_READY,
    output logic [7:0] BLK_Y0,
    output logic [7:0] BLK_Y1,
    output logic       BLK_FIRST,
    output logic       BLK_LAST,
    output logic       FRAME_DONE,
    output logic       OVERFLOW
);

    localparam int HW = WIDTH / 2;
    localparam int BX = WIDTH / 8;
    localparam int NB = HEIGHT / 8;
    localparam int XW = (BX > 1) ? $clog2(BX) : 1;
    localparam int CW = XW + 2;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    logic [7:0]    y0_p1, y1_p1;
    logic          vld_p1;
    logic [CW-1:0] wcol;
    logic [2:0]    wrow;
    logic [BW-1:0] wband;
    logic          wbank, rbank;
    logic [1:0]    full, full_nx, last_tag;
    logic          band_done, swap, release_bank, accept, ren;
    rd_state_t     state, state_nx;
    logic [XW-1:0] ibx;
    logic [4:0]    ibeat;
    logic [CW-1:0] rcol;
    logic [15:0]   rdata;
    logic          first_o, last_o, final_o;
    logic [15:0]   mem [2*BLK_N][HW];

    luma_conv u_luma0 (.clk(HCLK), .r(DATA_R0), .g(DATA_G0), .b(DATA_B0), .y(y0_p1));
    luma_conv u_luma1 (.clk(HCLK), .r(DATA_R1), .g(DATA_G1), .b(DATA_B1), .y(y1_p1));

    // p0 -> p1: qualifier follows the luma register
    always_ff @(posedge HCLK) begin
        if (HRESET) vld_p1 <= 1'b0;
        else        vld_p1 <= HSYNC;
    end

    assign band_done    = vld_p1 && (wcol == CW'(HW - 1)) && (wrow == 3'(BLK_N - 1));
    assign rbank        = ~wbank;
    assign accept       = (state == STREAM) && BLK_READY;
    assign release_bank = accept && final_o;

    // Release is applied before the full test, so a band finishing on the release cycle still swaps.
    always_comb begin
        full_nx = full;
        swap    = 1'b0;
        if (release_bank) full_nx[rbank] = 1'b0;
        if (band_done && !full_nx[rbank]) begin
            full_nx[wbank] = 1'b1;
            swap           = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wcol     <= '0;
            wrow     <= '0;
            wband    <= '0;
            wbank    <= 1'b0;
            full     <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            full <= full_nx;
            if (swap) wbank <= ~wbank;
            if (band_done && !swap) OVERFLOW <= 1'b1;
            if (vld_p1) begin
                if (wcol == CW'(HW - 1)) begin
                    wcol <= '0;
                    wrow <= wrow + 3'd1;
                    if (wrow == 3'(BLK_N - 1))
                        wband <= (wband == BW'(NB - 1)) ? '0 : wband + BW'(1);
                end else begin
                    wcol <= wcol + CW'(1);
                end
            end
        end
    end

    // p1 -> buffer: luma pair written one cycle after capture
    always_ff @(posedge HCLK) begin
        if (vld_p1) mem[{wbank, wrow}][wcol] <= {y1_p1, y0_p1};
        if (swap) last_tag[wbank] <= (wband == BW'(NB - 1));
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= IDLE;
        else        state <= state_nx;
    end

    // The read pointer runs one beat ahead of the output register; a read is issued only on acceptance.
    always_comb begin
        state_nx = state;
        ren      = 1'b0;
        case (state)
            IDLE:    if (|full) state_nx = PRIME;
            PRIME: begin
                ren      = 1'b1;
                state_nx = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    if (final_o) state_nx = IDLE;
                    else         ren      = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Within a block, beat 4r+p reads row r, word 4*bx+p.
    assign rcol = {ibx, ibeat[1:0]};

    always_ff @(posedge HCLK) begin
        if (HRESET || state == IDLE) begin
            ibeat <= '0;
            ibx   <= '0;
        end else if (ren) begin
            ibeat <= ibeat + 5'd1;
            if (ibeat == 5'(BEATS_PER_BLK - 1))
                ibx <= (ibx == XW'(BX - 1)) ? '0 : ibx + XW'(1);
        end
    end

    // buffer -> output: read data and beat tags update together, so a stall holds all of them
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rdata   <= '0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
            final_o <= 1'b0;
        end else if (ren) begin
            rdata   <= mem[{rbank, ibeat[4:2]}][rcol];
            first_o <= (ibeat == 5'd0);
            last_o  <= (ibeat == 5'(BEATS_PER_BLK - 1));
            final_o <= (ibeat == 5'(BEATS_PER_BLK - 1)) && (ibx == XW'(BX - 1));
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) FRAME_DONE <= 1'b0;
        else        FRAME_DONE <= release_bank && last_tag[rbank];
    end

    assign BLK_VALID = (state == STREAM);
    assign BLK_Y0    = rdata[7:0];
    assign BLK_Y1    = rdata[15:8];
    assign BLK_FIRST = first_o && BLK_VALID;
    assign BLK_LAST  = last_o && BLK_VALID;

endmodule

// File: doc/raster_to_block.md
RASTER_TO_BLOCK -- requirements
Module: raster_to_block

Interface
REQ-001 Parameter WIDTH, default 768, image width in pixels; multiple of 16.
REQ-002 Parameter HEIGHT, default 512, image height in pixels; multiple of 8.
REQ-003 HCLK  input  1  sole clock; all logic on rising edge.
REQ-004 HRESET  input  1  synchronous, active-high reset.
REQ-005 HSYNC  input  1  qualifies input pixel pair this cycle.
REQ-006 DATA_R0/G0/B0  input  8 each  left pixel of pair.
REQ-007 DATA_R1/G1/B1  input  8 each  right pixel of pair.
REQ-008 BLK_VALID  output  1  output beat valid.
REQ-009 BLK_READY  input  1  downstream accepts beat.
REQ-010 BLK_Y0, BLK_Y1  output  8 each  luma of left/right pixel of beat.
REQ-011 BLK_FIRST  output  1  beat 0 of an 8x8 block.
REQ-012 BLK_LAST  output  1  beat 31 of an 8x8 block.
REQ-013 FRAME_DONE  output  1  one-cycle pulse after last beat of frame accepted.
REQ-014 OVERFLOW  output  1  sticky: a band was discarded.

Function
REQ-015 Input is raster order, two pixels per HSYNC cycle, left to right, top to bottom; no backpressure on input.
REQ-016 Luma per pixel SHALL be Y = (77R + 150G + 29B + 128) >> 8, 16-bit intermediate, result 0..255, no saturation needed.
REQ-017 Luma conversion SHALL be one registered stage; buffer write occurs the cycle after HSYNC.
REQ-018 Buffer: two banks, each 8 rows x WIDTH/2 words of 16 bits (Y1:Y0); one write port, one read port, 1-cycle read latency.
REQ-019 Write counters: column word 0..WIDTH/2-1, band row 0..7, band index 0..HEIGHT/8-1; all wrap to 0 at their limits.
REQ-020 A bank is full when row 7, word WIDTH/2-1 is written; write side then swaps to the other bank.
REQ-021 Read FSM states: IDLE, PRIME, STREAM; IDLE->PRIME when a full bank exists; PRIME issues first read; PRIME->STREAM; STREAM->IDLE after last beat of last block of band accepted, and that bank is released.
REQ-022 Output order: blocks bx = 0..WIDTH/8-1 left to right; within a block beat b = 4r+p, Y0 = pixel(row r, col 8bx+2p), Y1 = pixel(r, 8bx+2p+1).
REQ-023 Beat transfers when BLK_VALID and BLK_READY both high; while BLK_VALID high and BLK_READY low, BLK_Y0/Y1/FIRST/LAST SHALL hold stable.
REQ-024 With BLK_READY held high, beats stream one per cycle without gaps within a band.
REQ-025 If a bank becomes full while the other bank is still being read, that band SHALL be discarded (no swap, next band overwrites it) and OVERFLOW set; bank being read is never corrupted.
REQ-026 FRAME_DONE pulses the cycle after the final beat of band HEIGHT/8-1 is accepted; discarded bands still count toward frame position.
REQ-027 Bank-full and read-release in the same cycle: release processed first, new band starts reading next cycle without overflow.

Reset
REQ-028 On HRESET all counters 0, FSM IDLE, both banks empty, write bank 0.
REQ-029 Reset outputs: BLK_VALID 0, BLK_Y0/Y1 0, BLK_FIRST 0, BLK_LAST 0, FRAME_DONE 0, OVERFLOW 0.
REQ-030 Reset mid-band or mid-block discards all buffered data; next HSYNC pixel is treated as frame pixel (0,0).

Structure
REQ-031 Shared package raster_block_pkg holds BLK_N=8, BEATS_PER_BLK=32, luma coefficients 77/150/29, and the FSM state enum.
REQ-032 Luma conversion SHALL be sub-module luma_conv (one instance per pixel, two instances).

Verification
REQ-033 Reset: assert HRESET 3 cycles -> all outputs 0, no BLK_VALID until a full band is written.
REQ-034 WIDTH=16, HEIGHT=8, all pixels R=G=B=100, BLK_READY=1 -> 64 beats, all Y0=Y1=100, FIRST on beats 0/32, LAST on 31/63, one FRAME_DONE.
REQ-035 Gray ramp R=G=B=column -> block 0 beat 0 Y0=0,Y1=1; beat 3 Y0=6,Y1=7; block 1 beat 0 Y0=8,Y1=9.
REQ-036 BLK_READY low 5 cycles at block 0 beat 10 -> data held, no beat lost or duplicated, totals unchanged.
REQ-037 BLK_READY held low across writing bands 0,1,2 (HEIGHT=24) -> OVERFLOW=1, band 0 output intact, band 2 discarded.
REQ-038 HRESET at band row 4 -> outputs 0, subsequent full frame reproduces REQ-034 results.
